// File: rtl/tx_uart_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// 1 or 2 stop bits, then a one-cycle done state that can accept the next
// request. Each bit is held for BPS_T clock cycles.
module tx_uart_module #(
  parameter logic [12:0] BPS_T      = 13'd52,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        PARITY_ODD = 1'b0,
  parameter logic [1:0]  STOP_BITS  = 2'd1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Pin_Out,
  output logic       TX_Busy,
  output logic       TX_Done_Sig
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Index of the final stop bit; anything other than 2 means one stop bit.
  localparam logic LAST_STOP = (STOP_BITS == 2'd2);

  logic [2:0]  state;
  logic [12:0] count_bps;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        bit_end;
  logic        ready;

  assign bit_end = (count_bps == BPS_T - 13'd1);
  assign ready   = (state == IDLE) || (state == DONE);

  // Bit-period counter: runs only while a frame bit is on the line.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_bps <= '0;
    end else if (ready || bit_end) begin
      count_bps <= '0;
    end else begin
      count_bps <= count_bps + 13'd1;
    end
  end

  // Frame sequencer: drives the registered pin value for the next bit at each boundary.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      TX_Pin_Out  <= 1'b1;
      TX_Busy     <= 1'b0;
      TX_Done_Sig <= 1'b0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
    end else begin
      TX_Done_Sig <= 1'b0;
      case (state)
        IDLE, DONE: begin
          TX_Pin_Out <= 1'b1;
          TX_Busy    <= 1'b0;
          if (TX_En_Sig) begin
            state      <= START;
            shift_reg  <= TX_Data;
            parity_bit <= (^TX_Data) ^ PARITY_ODD;
            TX_Pin_Out <= 1'b0;
            TX_Busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            state      <= DATA;
            TX_Pin_Out <= shift_reg[0];
            shift_reg  <= {1'b0, shift_reg[7:1]};
            bit_idx    <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY_EN) begin
                state      <= PARITY;
                TX_Pin_Out <= parity_bit;
              end else begin
                state      <= STOP;
                TX_Pin_Out <= 1'b1;
                stop_idx   <= 1'b0;
              end
            end else begin
              TX_Pin_Out <= shift_reg[0];
              shift_reg  <= {1'b0, shift_reg[7:1]};
              bit_idx    <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state      <= STOP;
            TX_Pin_Out <= 1'b1;
            stop_idx   <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              state       <= DONE;
              TX_Busy     <= 1'b0;
              TX_Done_Sig <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          TX_Pin_Out <= 1'b1;
          TX_Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart_module.sv
// Bench for tx_uart_module: three configurations driven by shared stimulus,
// each compared every cycle against a frame-level reference model.
module tb_tx_uart_module;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [2:0] pin;
  logic [2:0] busy;
  logic [2:0] done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_uart_module #(.BPS_T(13'd52)) u0 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en), .TX_Data(data),
    .TX_Pin_Out(pin[0]), .TX_Busy(busy[0]), .TX_Done_Sig(done[0])
  );

  tx_uart_module #(.BPS_T(13'd7), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2'd2)) u1 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en), .TX_Data(data),
    .TX_Pin_Out(pin[1]), .TX_Busy(busy[1]), .TX_Done_Sig(done[1])
  );

  tx_uart_module #(.BPS_T(13'd2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2'd3)) u2 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en), .TX_Data(data),
    .TX_Pin_Out(pin[2]), .TX_Busy(busy[2]), .TX_Done_Sig(done[2])
  );

  // Configuration of each instance as the model sees it (STOP_BITS=3 means one stop bit).
  int bps[3]   = '{52, 7, 2};
  int pen[3]   = '{0, 1, 1};
  int podd[3]  = '{0, 0, 1};
  int nstop[3] = '{1, 2, 1};

  // Model state: acceptance edge, active flag and byte of each frame.
  int         cyc = 0;
  int         t_acc[3];
  bit         act[3];
  logic [7:0] byt[3];
  logic       e_pin[3];
  logic       e_busy[3];
  logic       e_done[3];
  int         exp_dones[3];
  int         seen_dones[3];

  function automatic int flen(input int i);
    return bps[i] * (9 + pen[i] + nstop[i]);
  endfunction

  // Line level during frame cycle k (1-based) for byte d.
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int k);
    int idx;
    idx = (k - 1) / bps[i];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pen[i] == 1 && idx == 9) return (^d) ^ (podd[i] != 0);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      int L;
      int k;
      L = flen(i);
      if (!rst_n) begin
        act[i] = 1'b0;
      end else if (en && (!act[i] || (cyc - t_acc[i] >= L + 1))) begin
        act[i]   = 1'b1;
        t_acc[i] = cyc;
        byt[i]   = data;
      end
      k = cyc - t_acc[i] + 1;
      if (act[i] && k > L + 1) act[i] = 1'b0;
      e_pin[i]  = 1'b1;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
      if (act[i]) begin
        if (k <= L) begin
          e_pin[i]  = exp_bit(i, byt[i], k);
          e_busy[i] = 1'b1;
        end else begin
          e_done[i] = 1'b1;
          exp_dones[i]++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d pin @%0d", i, cyc), 32'(pin[i]), 32'(e_pin[i]));
      check($sformatf("u%0d busy @%0d", i, cyc), 32'(busy[i]), 32'(e_busy[i]));
      check($sformatf("u%0d done @%0d", i, cyc), 32'(done[i]), 32'(e_done[i]));
      if (done[i] === 1'b1) seen_dones[i]++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    en   = 1'b1;
    data = d;
    step();
    en   = 1'b0;
    data = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_acc[i] = 0; act[i] = 1'b0; byt[i] = '0;
      exp_dones[i] = 0; seen_dones[i] = 0;
    end

    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    // Basic frame
    send(8'h55);
    repeat (600) step();

    // Request during busy is ignored; data changes after acceptance do not matter
    send(8'h0F);
    repeat (98) step();
    en = 1'b1; data = 8'hFF;
    step();
    en = 1'b0;
    repeat (500) begin
      data = 8'($urandom);
      step();
    end

    // Parity bit values
    send(8'h07);
    repeat (600) step();

    // Back-to-back with request held high
    en = 1'b1; data = 8'h00;
    step();
    data = 8'hFF;
    repeat (1100) step();
    en = 1'b0;
    repeat (600) step();

    // Asynchronous reset mid-frame, then reset together with a request
    send(8'h00);
    repeat (198) step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) act[i] = 1'b0;
    check("async rst pin", 32'(pin[0]), 32'd1);
    check("async rst busy", 32'(busy[0]), 32'd0);
    check("async rst done", 32'(done[0]), 32'd0);
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    rst_n = 1'b1;
    repeat (5) step();
    send(8'($urandom));
    repeat (600) step();

    // Random traffic
    repeat (4000) begin
      en   = ($urandom_range(0, 39) == 0);
      data = 8'($urandom);
      step();
    end
    en = 1'b0;
    repeat (700) step();

    for (int i = 0; i < 3; i++)
      check($sformatf("u%0d done count", i), 32'(seen_dones[i]), 32'(exp_dones[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_uart_module.md
Name: tx_uart_module

Overview:
- UART transmitter. Counterpart of the receive path.
- Serialises one byte per request as a frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Contains its own bit-period counter: same clock (500 kHz) and same BPS_T divisor scheme as the RX side (500 kHz / 9600 baud ≈ 52).
- Sits between the system-side byte producer and the TX pin. Handshake is a single-cycle request in, a single-cycle done pulse out.

Parameters:
- BPS_T, 13'd52: clock cycles per bit. Legal range 2..8191.
- PARITY_EN, 1'b0: 1 inserts a parity bit after D7.
- PARITY_ODD, 1'b0: parity sense when PARITY_EN=1. 0 = even, 1 = odd.
- STOP_BITS, 2'd1: number of stop bits. Legal values 1 or 2.

Ports:
- CLK, input, 1: system clock, 500 kHz.
- RSTn, input, 1: asynchronous active-low reset.
- TX_En_Sig, input, 1: transmit request. Sampled high while idle → start a frame.
- TX_Data, input, 8: byte to send. Captured in the cycle TX_En_Sig is accepted.
- TX_Pin_Out, output, 1: serial line. Registered output; idles high.
- TX_Busy, output, 1: high from the cycle after acceptance until the frame completes.
- TX_Done_Sig, output, 1: one-cycle pulse marking frame completion.

Behaviour:
- Reset (async, RSTn=0): TX_Pin_Out=1, TX_Busy=0, TX_Done_Sig=0, state=IDLE, bit counter=0, Count_BPS=0, shift register=0. Applies immediately, including mid-frame. Aborted frame produces no TX_Done_Sig.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: TX_Pin_Out=1, TX_Busy=0.
  - If TX_En_Sig=1 at edge E0: latch TX_Data into the shift register, compute the parity bit (XOR of data bits, inverted if PARITY_ODD), go to START.
- Bit timing:
  - Count_BPS is 13 bits. It counts 0..BPS_T-1 in every non-IDLE bit state.
  - On Count_BPS==BPS_T-1: wrap to 0 and advance to the next bit.
  - Every bit is held for exactly BPS_T cycles.
  - TX_Pin_Out changes only at bit boundaries: no glitches, no mid-bit changes.
- START: TX_Pin_Out=0, from cycle E0+1 for BPS_T cycles.
- DATA: shift register bit 0 drives the pin; shift right at each bit boundary. A 3-bit index counts 0..7; after bit 7 go to PARITY if PARITY_EN, else STOP.
- PARITY: drives the computed parity bit for BPS_T cycles.
- STOP: TX_Pin_Out=1 for STOP_BITS×BPS_T cycles.
- DONE: lasts exactly one cycle.
  - TX_Done_Sig=1, TX_Busy=0, TX_Pin_Out=1.
  - Behaves as IDLE for request acceptance: a TX_En_Sig in this cycle is accepted, and its start bit begins the next cycle. This gives back-to-back frames with exactly one extra idle-high cycle.
- Frame length: L = BPS_T × (9 + PARITY_EN + STOP_BITS) cycles, from E0+1 through E0+L. TX_Done_Sig is asserted at cycle E0+L+1.
- TX_Busy=1 in cycles E0+1 .. E0+L.
- TX_En_Sig while TX_Busy=1 is ignored; no queueing.
- Changes on TX_Data after acceptance do not affect the frame in flight.
- Simultaneous reset and TX_En_Sig: reset wins; no frame starts.
- Illegal STOP_BITS values (0 or 3) are treated as 1 stop bit.

Test Plan:
- Basic frame: BPS_T=52, defaults, TX_Data=8'h55, TX_En_Sig pulsed at E0 → pin 0 for cycles 1–52, then alternating 1,0,1,0,1,0,1,0 (52 cycles each), high for cycles 469–520; TX_Done_Sig=1 only at cycle 521; TX_Busy=1 for cycles 1–520.
- Parity: PARITY_EN=1, PARITY_ODD=0, TX_Data=8'h07 → parity bit=1 during cycles 469–520; stop bit 521–572; done at 573. Repeat with PARITY_ODD=1 → parity bit=0.
- Two stop bits: STOP_BITS=2, TX_Data=8'hA3 → pin high cycles 469–572; done at 573; data bits read back LSB-first equal 8'hA3.
- Busy rejection and data hold: TX_Data=8'h0F accepted; at cycle 100 assert TX_En_Sig with TX_Data=8'hFF → transmitted byte remains 8'h0F; single done pulse; no second frame.
- Back-to-back: TX_En_Sig held high with TX_Data=8'h00, then 8'hFF → second start bit begins at cycle 522; pin is high in cycle 521 only; two done pulses 521 cycles apart.
- Reset mid-frame: drop RSTn at cycle 200 of an 8'h00 frame → TX_Pin_Out=1 and TX_Busy=0 within the same cycle (async); no done pulse; after release, a new request sends a correct full frame.
